// File: rtl/roulette_wheel_spinner.sv
// roulette_wheel_spinner
//   Produces the 5-bit random number for the roulette game. A spin request starts the wheel at
//   a position taken from a free-running LFSR, steps it with ever-longer intervals (deceleration)
//   and finally lands, presenting the result until the next accepted request.
// Ports
//   i_clk        system clock, posedge
//   i_reset      asynchronous, active-high; returns to IDLE with all outputs cleared
//   i_spin_req   request a spin; honoured in IDLE or DONE, ignored while spinning
//   o_randnum    landed result, stable while o_num_valid is high
//   o_num_valid  high from landing until the next accepted request or reset
//   o_spin_done  one-cycle pulse on landing
//   o_busy       high while the wheel is spinning
//   o_wheel_pos  live wheel position for the display (0 in IDLE)
module roulette_wheel_spinner #(
    parameter int unsigned NUM_MAX   = 31,
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned START_DIV = 2_500_000,
    parameter int unsigned STEP_DIV  = 500_000,
    parameter int unsigned STOP_DIV  = 25_000_000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spin_req,
    output logic [4:0] o_randnum,
    output logic       o_num_valid,
    output logic       o_spin_done,
    output logic       o_busy,
    output logic [4:0] o_wheel_pos
);

    // One extra bit so interval + STEP_DIV never overflows before the stop compare.
    localparam int unsigned IW = CNT_W + 1;

    localparam logic [IW-1:0] START_V  = IW'(START_DIV);
    localparam logic [IW-1:0] STEP_V   = IW'(STEP_DIV);
    localparam logic [IW-1:0] STOP_V   = IW'(STOP_DIV);
    localparam logic [5:0]    NUM_MOD  = 6'(NUM_MAX + 1);
    // An all-zero LFSR would lock up.
    localparam logic [15:0]   SEED_V   = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {StIdle, StSpin, StDone} state_t;

    state_t           r_state, w_state_next;
    logic [15:0]      r_lfsr, w_lfsr_next;
    logic [4:0]       r_pos, w_pos_next;
    logic [CNT_W-1:0] r_tick, w_tick_next;
    logic [IW-1:0]    r_interval, w_interval_next;
    logic [4:0]       r_randnum, w_randnum_next;
    logic             r_num_valid, w_num_valid_next;
    logic             r_spin_done, w_spin_done_next;
    logic             r_busy, w_busy_next;

    logic             w_lfsr_fb;
    logic [IW-1:0]    w_int_step;
    logic             w_tick_last;
    logic [4:0]       w_pos_inc;

    // Bring v (at most 2*NUM_MAX+1) back into 0..NUM_MAX.
    function automatic logic [4:0] wrap(input logic [5:0] v);
        logic [5:0] t;
        t = (v >= NUM_MOD) ? (v - NUM_MOD) : v;
        return t[4:0];
    endfunction

    always_comb begin
        // Fibonacci LFSR, taps 16,14,13,11
        w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_lfsr_next = {r_lfsr[14:0], w_lfsr_fb};

        w_int_step  = r_interval + STEP_V;
        w_tick_last = ({1'b0, r_tick} == (r_interval - IW'(1)));
        w_pos_inc   = wrap({1'b0, r_pos} + 6'd1);

        w_state_next     = r_state;
        w_pos_next       = r_pos;
        w_tick_next      = r_tick;
        w_interval_next  = r_interval;
        w_randnum_next   = r_randnum;
        w_num_valid_next = r_num_valid;
        w_spin_done_next = 1'b0;
        w_busy_next      = r_busy;

        case (r_state)
            StIdle, StDone: begin
                if (i_spin_req) begin
                    w_state_next     = StSpin;
                    w_pos_next       = wrap({1'b0, r_lfsr[4:0]});
                    w_tick_next      = '0;
                    w_interval_next  = START_V;
                    w_busy_next      = 1'b1;
                    w_num_valid_next = 1'b0;
                end
            end
            StSpin: begin
                w_tick_next = r_tick + CNT_W'(1);
                if (w_tick_last) begin
                    w_tick_next     = '0;
                    w_pos_next      = w_pos_inc;
                    w_interval_next = w_int_step;
                    // Land when the next interval would be too slow.
                    if (w_int_step > STOP_V) begin
                        w_state_next     = StDone;
                        w_randnum_next   = w_pos_inc;
                        w_num_valid_next = 1'b1;
                        w_spin_done_next = 1'b1;
                        w_busy_next      = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_lfsr      <= SEED_V;
            r_pos       <= '0;
            r_tick      <= '0;
            r_interval  <= '0;
            r_randnum   <= '0;
            r_num_valid <= 1'b0;
            r_spin_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_pos       <= w_pos_next;
            r_tick      <= w_tick_next;
            r_interval  <= w_interval_next;
            r_randnum   <= w_randnum_next;
            r_num_valid <= w_num_valid_next;
            r_spin_done <= w_spin_done_next;
            r_busy      <= w_busy_next;
        end
    end

    assign o_randnum   = r_randnum;
    assign o_num_valid = r_num_valid;
    assign o_spin_done = r_spin_done;
    assign o_busy      = r_busy;
    assign o_wheel_pos = (r_state == StIdle) ? 5'd0 : r_pos;

endmodule
